// File: rtl/serdes_align_ctrl.sv
// Training controller for one ISERDESE2 + IDELAYE2 lane (CLKDIV domain).
// Sweeps all 32 delay taps, loads the centre of the widest passing window, then bitslips to word lock.
module serdes_align_ctrl #(
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'h6A),
  parameter int                    SAMPLES       = 16,
  parameter int                    SETTLE_CYCLES = 8,
  parameter int                    BITSLIP_WAIT  = 4,
  parameter int                    MIN_WINDOW    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  dly_ld_o,
  output logic [4:0]            dly_cntvalue_o,
  output logic                  bitslip_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [4:0]            tap_o,
  output logic [5:0]            window_len_o,
  output logic [2:0]            slip_cnt_o
);

  localparam int CMAX0 = (SAMPLES > SETTLE_CYCLES) ? SAMPLES : SETTLE_CYCLES;
  localparam int CMAX  = (CMAX0 > BITSLIP_WAIT) ? CMAX0 : BITSLIP_WAIT;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLES - 1);
  localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] BSW_LAST  = CW'(BITSLIP_WAIT - 1);
  localparam logic [2:0]    SLIP_MAX  = 3'(DATA_WIDTH - 1);
  localparam logic [5:0]    MIN_WIN   = 6'(MIN_WINDOW);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SWEEP, S_ALIGN, S_SLIP, S_SLIPW, S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [4:0]            r_tap, w_tap;
  logic                  r_align, w_align;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_ref, w_ref;
  logic [4:0]            r_cur_start, w_cur_start;
  logic [5:0]            r_cur_len, w_cur_len;
  logic [4:0]            r_best_start, w_best_start;
  logic [5:0]            r_best_len, w_best_len;
  logic [2:0]            r_slips, w_slips;
  logic                  r_ld, w_ld;
  logic                  r_bs, w_bs;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_err, w_err;
  logic [4:0]            r_tap_out, w_tap_out;

  // True when w is TRAIN_PATTERN rotated by any amount 0..DATA_WIDTH-1.
  function automatic logic is_rot(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    logic                  hit;
    hit = 1'b0;
    r   = TRAIN_PATTERN;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (w == r) hit = 1'b1;
      r = {r[DATA_WIDTH-2:0], r[DATA_WIDTH-1]};
    end
    return hit;
  endfunction

  // Sweep bookkeeping, valid on the cycle a tap verdict is reached.
  logic       w_word_ok;
  logic [5:0] w_run_len;
  logic [4:0] w_run_start;
  logic       w_newbest;
  logic [5:0] w_win_len;
  logic [4:0] w_win_start;
  logic [4:0] w_centre;

  assign w_word_ok   = (r_cnt == '0) ? is_rot(data_i) : (data_i == r_ref);
  assign w_run_len   = w_word_ok ? (r_cur_len + 6'd1) : 6'd0;
  assign w_run_start = (w_word_ok && (r_cur_len == 6'd0)) ? r_tap : r_cur_start;
  assign w_newbest   = (w_run_len > r_best_len);
  assign w_win_len   = w_newbest ? w_run_len : r_best_len;
  assign w_win_start = w_newbest ? w_run_start : r_best_start;
  assign w_centre    = w_win_start + 5'(w_win_len >> 1);

  always_comb begin
    w_state      = r_state;
    w_tap        = r_tap;
    w_align      = r_align;
    w_cnt        = r_cnt;
    w_ref        = r_ref;
    w_cur_start  = r_cur_start;
    w_cur_len    = r_cur_len;
    w_best_start = r_best_start;
    w_best_len   = r_best_len;
    w_slips      = r_slips;
    w_ld         = 1'b0;
    w_bs         = 1'b0;
    w_busy       = r_busy;
    w_done       = r_done;
    w_err        = r_err;
    w_tap_out    = r_tap_out;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        if (start_i) begin
          w_tap        = 5'd0;
          w_align      = 1'b0;
          w_cnt        = '0;
          w_cur_start  = 5'd0;
          w_cur_len    = 6'd0;
          w_best_start = 5'd0;
          w_best_len   = 6'd0;
          w_slips      = 3'd0;
          w_done       = 1'b0;
          w_err        = 1'b0;
          w_busy       = 1'b1;
          w_state      = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ld    = 1'b1;
        w_cnt   = '0;
        w_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SETL_LAST) begin
          w_cnt   = '0;
          w_state = r_align ? S_ALIGN : S_SWEEP;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_SWEEP: begin
        if (r_cnt == '0) w_ref = data_i;
        if (!w_word_ok || (r_cnt == SAMP_LAST)) begin
          w_cnt        = '0;
          w_cur_len    = w_run_len;
          w_cur_start  = w_run_start;
          w_best_len   = w_win_len;
          w_best_start = w_win_start;
          if (r_tap != 5'd31) begin
            w_tap   = r_tap + 5'd1;
            w_state = S_LOAD;
          end else if (w_win_len < MIN_WIN) begin
            w_err     = 1'b1;
            w_done    = 1'b1;
            w_busy    = 1'b0;
            w_tap_out = r_tap;
            w_state   = S_DONE;
          end else begin
            w_tap   = w_centre;
            w_align = 1'b1;
            w_state = S_LOAD;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_ALIGN: begin
        if (data_i != TRAIN_PATTERN) begin
          w_cnt = '0;
          if (r_slips != SLIP_MAX) begin
            w_state = S_SLIP;
          end else begin
            w_err     = 1'b1;
            w_done    = 1'b1;
            w_busy    = 1'b0;
            w_tap_out = r_tap;
            w_state   = S_DONE;
          end
        end else if (r_cnt == SAMP_LAST) begin
          w_cnt     = '0;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_tap_out = r_tap;
          w_state   = S_DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_SLIP: begin
        w_bs    = 1'b1;
        w_slips = r_slips + 3'd1;
        w_cnt   = '0;
        w_state = S_SLIPW;
      end
      S_SLIPW: begin
        if (r_cnt == BSW_LAST) begin
          w_cnt   = '0;
          w_state = S_ALIGN;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_tap        <= 5'd0;
      r_align      <= 1'b0;
      r_cnt        <= '0;
      r_ref        <= '0;
      r_cur_start  <= 5'd0;
      r_cur_len    <= 6'd0;
      r_best_start <= 5'd0;
      r_best_len   <= 6'd0;
      r_slips      <= 3'd0;
      r_ld         <= 1'b0;
      r_bs         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tap_out    <= 5'd0;
    end else begin
      r_state      <= w_state;
      r_tap        <= w_tap;
      r_align      <= w_align;
      r_cnt        <= w_cnt;
      r_ref        <= w_ref;
      r_cur_start  <= w_cur_start;
      r_cur_len    <= w_cur_len;
      r_best_start <= w_best_start;
      r_best_len   <= w_best_len;
      r_slips      <= w_slips;
      r_ld         <= w_ld;
      r_bs         <= w_bs;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
      r_tap_out    <= w_tap_out;
    end
  end

  // LD and BITSLIP are registered so each is a clean single-cycle pulse.
  assign dly_ld_o       = r_ld;
  assign dly_cntvalue_o = r_tap;
  assign bitslip_o      = r_bs;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign error_o        = r_err;
  assign tap_o          = r_tap_out;
  assign window_len_o   = r_best_len;
  assign slip_cnt_o     = r_slips;

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Scoreboard bench for serdes_align_ctrl: a lane model drives data from the loaded tap and bitslips,
// expected training results come from a window-scan reference model.
module tb_serdes_align_ctrl;
  localparam int         DW  = 8;
  localparam logic [7:0] PAT = 8'h6A;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       dly_ld_o, bitslip_o, busy_o, done_o, error_o;
  logic [4:0] dly_cntvalue_o, tap_o;
  logic [5:0] window_len_o;
  logic [2:0] slip_cnt_o;

  serdes_align_ctrl #(
    .DATA_WIDTH(8), .TRAIN_PATTERN(8'h6A), .SAMPLES(16),
    .SETTLE_CYCLES(8), .BITSLIP_WAIT(4), .MIN_WINDOW(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .data_i(data_i),
    .dly_ld_o(dly_ld_o), .dly_cntvalue_o(dly_cntvalue_o), .bitslip_o(bitslip_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .tap_o(tap_o),
    .window_len_o(window_len_o), .slip_cnt_o(slip_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int err; int tap; int win; int slips; int lds; int bss;
  } exp_t;
  exp_t q[$];

  // Lane configuration: which taps sample cleanly, word rotation, whether BITSLIP rotates the word.
  logic [31:0] pass_mask = 32'h0;
  int          rot = 0;
  bit          respond = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] p, input int n);
    logic [7:0] r;
    r = p;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = 32'h0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Reference: find maximal runs of passing taps, keep the first longest, derive centre and slips.
  function automatic exp_t model(input logic [31:0] m, input int r, input bit resp);
    exp_t e;
    int   t, s, bl, bst, need;
    bl = 0; bst = 0; t = 0;
    while (t < 32) begin
      if (!m[t]) t++;
      else begin
        s = t;
        while (t < 32 && m[t]) t++;
        if (t - s > bl) begin bl = t - s; bst = s; end
      end
    end
    e.win = bl;
    if (bl < 4) begin
      e.err = 1; e.tap = 31; e.slips = 0; e.lds = 32; e.bss = 0;
    end else begin
      e.tap = bst + bl / 2;
      e.lds = 33;
      if (resp) need = (DW - (r % DW)) % DW;
      else      need = ((r % DW) == 0) ? 0 : DW;
      if (need <= DW - 1) begin e.err = 0; e.slips = need; end
      else                begin e.err = 1; e.slips = DW - 1; end
      e.bss = e.slips;
    end
    return e;
  endfunction

  // Lane model: passing taps give a steady rotated pattern, failing taps give changing junk.
  initial begin : lane
    logic [4:0] ltap;
    int         lslip;
    logic [7:0] nw;
    ltap = 5'd0; lslip = 0;
    forever begin
      @(negedge clk_i);
      if (dly_ld_o) begin ltap = dly_cntvalue_o; lslip = 0; end
      if (bitslip_o) lslip++;
      if (pass_mask[ltap]) data_i = rotl(PAT, respond ? (rot + lslip) % DW : rot);
      else begin
        nw = 8'($urandom);
        if (nw == data_i) nw = nw ^ 8'h01;
        data_i = nw;
      end
    end
  end

  // Monitor: counts pulses per run and checks the result when done_o rises.
  initial begin : monitor
    bit done_q, busy_q, both;
    int ld_n, bs_n;
    exp_t e;
    done_q = 0; busy_q = 0; both = 0; ld_n = 0; bs_n = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin done_q = 0; busy_q = 0; continue; end
      if (busy_o && !busy_q) begin ld_n = 0; bs_n = 0; both = 0; end
      if (dly_ld_o) ld_n++;
      if (bitslip_o) bs_n++;
      if (dly_ld_o && bitslip_o) both = 1;
      if (done_o && !done_q) begin
        if (q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          e = q.pop_front();
          chk("busy_at_done", int'(busy_o), 0);
          chk("error", int'(error_o), e.err);
          chk("tap", int'(tap_o), e.tap);
          chk("window_len", int'(window_len_o), e.win);
          chk("slip_cnt", int'(slip_cnt_o), e.slips);
          chk("ld_pulses", ld_n, e.lds);
          chk("bitslip_pulses", bs_n, e.bss);
          chk("ld_bs_overlap", int'(both), 0);
        end
      end
      done_q = done_o; busy_q = busy_o;
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic run_case(input logic [31:0] m, input int r, input bit resp, input bit mid_start);
    bit seen;
    pass_mask = m; rot = r; respond = resp;
    q.push_back(model(m, r, resp));
    @(negedge clk_i);
    pulse_start();
    chk("busy_rise", int'(busy_o), 1);
    chk("ld_not_yet", int'(dly_ld_o), 0);
    @(negedge clk_i);
    chk("first_ld", int'(dly_ld_o), 1);
    if (mid_start) begin
      repeat (150) @(negedge clk_i);
      pulse_start();
    end
    seen = 0;
    for (int i = 0; i < 6000; i++) begin
      if (done_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    chk("done_timeout", int'(seen), 1);
    @(negedge clk_i);
  endtask

  initial begin : stim
    bit quiet, seen;
    logic [31:0] m;
    int lo, len;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_ld", int'(dly_ld_o), 0);
    chk("rst_tap", int'(tap_o), 0);
    chk("rst_win", int'(window_len_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_case(span(10, 19), 3, 1, 0);
    run_case(span(2, 7) | span(20, 25), 0, 1, 0);
    run_case(span(29, 31), 2, 1, 0);
    run_case(32'hFFFF_FFFF, 0, 1, 0);
    run_case(span(10, 19), 1, 0, 0);

    // Reset while waiting after a bitslip.
    pass_mask = span(10, 19); rot = 3; respond = 1;
    @(negedge clk_i);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bitslip_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    chk("slip_seen", int'(seen), 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_bs", int'(bitslip_o), 0);
    chk("midrst_slips", int'(slip_cnt_o), 0);
    chk("midrst_cntval", int'(dly_cntvalue_o), 0);
    chk("midrst_win", int'(window_len_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    quiet = 1;
    repeat (60) begin
      @(negedge clk_i);
      if (dly_ld_o || bitslip_o || busy_o || done_o) quiet = 0;
    end
    chk("post_reset_quiet", int'(quiet), 1);

    run_case(span(4, 20), 6, 1, 1);

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          lo = $urandom_range(0, 31);
          len = $urandom_range(1, 32 - lo);
          m = span(lo, lo + len - 1);
        end
        1: m = $urandom;
        default: begin
          lo = $urandom_range(0, 12);
          m = span(lo, lo + $urandom_range(0, 8)) | span(lo + 12, lo + 12 + $urandom_range(0, 7));
        end
      endcase
      run_case(m, $urandom_range(0, 7), ($urandom_range(0, 3) != 0), 0);
    end

    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
